// File: rtl/pipe_pkg.sv
// Shared encodings and helpers for the NPC pipeline hazard controller.
package pipe_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_X    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_W    = 2'b11;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // A valid, register-writing stage whose destination matches a non-x0 source.
    function automatic logic stage_hit(input logic v, input logic wen,
                                       input logic [4:0] rd, input logic [4:0] r);
        return v & wen & (rd == r) & (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/raw_detect.sv
// RAW hazard and forwarding-select logic for one source operand of the D stage.
module raw_detect
    import pipe_pkg::*;
#(
    parameter bit FwdEn = 1'b1
) (
    input  logic [4:0] rs_i,
    input  logic       use_i,
    input  logic       vd_i,
    input  logic       vx_i,
    input  logic       x_wen_i,
    input  logic [4:0] x_rd_i,
    input  logic       x_load_i,
    input  logic       vm_i,
    input  logic       m_wen_i,
    input  logic [4:0] m_rd_i,
    input  logic       vw_i,
    input  logic       w_wen_i,
    input  logic [4:0] w_rd_i,
    output logic       lu_o,
    output logic [1:0] fwd_o
);

    logic hit_x, hit_m, hit_w;

    assign hit_x = stage_hit(vx_i, x_wen_i, x_rd_i, rs_i);
    assign hit_m = stage_hit(vm_i, m_wen_i, m_rd_i, rs_i);
    assign hit_w = stage_hit(vw_i, w_wen_i, w_rd_i, rs_i);

    // Without forwarding every in-flight producer blocks the consumer.
    assign lu_o = FwdEn ? (vd_i & use_i & x_load_i & hit_x)
                        : (vd_i & use_i & (hit_x | hit_m | hit_w));

    always_comb begin
        fwd_o = FWD_RF;
        if (FwdEn) begin
            if (hit_x && !x_load_i) begin
                fwd_o = FWD_X;
            end else if (hit_m) begin
                fwd_o = FWD_M;
            end else if (hit_w) begin
                fwd_o = FWD_W;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage valids, load enables, stall/flush control and forwarding selects.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W  = 32,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    output logic             if_flush,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_use1,
    input  logic             d_use2,
    input  logic [4:0]       x_rd,
    input  logic [4:0]       m_rd,
    input  logic [4:0]       w_rd,
    input  logic             x_wen,
    input  logic             m_wen,
    input  logic             w_wen,
    input  logic             x_load,
    input  logic             m_memop,
    input  logic             lsu_done,
    input  logic             x_redirect,
    output logic             en_D,
    output logic             en_X,
    output logic             en_M,
    output logic             en_W,
    output logic             vD,
    output logic             vX,
    output logic             vM,
    output logic             vW,
    output logic [1:0]       fwd1,
    output logic [1:0]       fwd2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             vd_q, vx_q, vm_q, vw_q;
    logic             vd_d, vx_d, vm_d, vw_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             lu1, lu2, lu, m_hold, redir, adv_d;
    logic [1:0]       fwd1_raw, fwd2_raw;

    raw_detect #(.FwdEn(FWD_EN)) u_raw_rs1 (
        .rs_i(d_rs1), .use_i(d_use1), .vd_i(vd_q),
        .vx_i(vx_q), .x_wen_i(x_wen), .x_rd_i(x_rd), .x_load_i(x_load),
        .vm_i(vm_q), .m_wen_i(m_wen), .m_rd_i(m_rd),
        .vw_i(vw_q), .w_wen_i(w_wen), .w_rd_i(w_rd),
        .lu_o(lu1), .fwd_o(fwd1_raw)
    );

    raw_detect #(.FwdEn(FWD_EN)) u_raw_rs2 (
        .rs_i(d_rs2), .use_i(d_use2), .vd_i(vd_q),
        .vx_i(vx_q), .x_wen_i(x_wen), .x_rd_i(x_rd), .x_load_i(x_load),
        .vm_i(vm_q), .m_wen_i(m_wen), .m_rd_i(m_rd),
        .vw_i(vw_q), .w_wen_i(w_wen), .w_rd_i(w_rd),
        .lu_o(lu2), .fwd_o(fwd2_raw)
    );

    assign m_hold = vm_q & m_memop & ~lsu_done;
    assign redir  = vx_q & x_redirect & ~m_hold;
    assign lu     = lu1 | lu2;
    assign adv_d  = (~m_hold & ~lu) | redir;

    always_comb begin
        vw_d        = vm_q & ~m_hold;
        vm_d        = m_hold ? vm_q : vx_q;
        vx_d        = vx_q;
        vd_d        = vd_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!m_hold) begin
            vx_d = (redir || lu) ? 1'b0 : vd_q;
        end
        if (redir) begin
            vd_d        = 1'b0;
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (adv_d) begin
            vd_d = if_valid;
        end
        if (lu && !m_hold && !redir) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vd_q        <= 1'b0;
            vx_q        <= 1'b0;
            vm_q        <= 1'b0;
            vw_q        <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            vd_q        <= vd_d;
            vx_q        <= vx_d;
            vm_q        <= vm_d;
            vw_q        <= vw_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Combinational outputs are forced quiet while reset is asserted.
    assign en_W      = ~rst;
    assign en_M      = ~rst & ~m_hold;
    assign en_X      = ~rst & ~m_hold;
    assign en_D      = ~rst & adv_d;
    assign if_ready  = ~rst & adv_d & ~redir;
    assign if_flush  = ~rst & redir;
    assign fwd1      = rst ? FWD_RF : fwd1_raw;
    assign fwd2      = rst ? FWD_RF : fwd2_raw;
    assign vD        = vd_q;
    assign vX        = vx_q;
    assign vM        = vm_q;
    assign vW        = vw_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic        clk, rst;
    logic        if_valid, if_ready, if_flush;
    logic [4:0]  d_rs1, d_rs2, x_rd, m_rd, w_rd;
    logic        d_use1, d_use2, x_wen, m_wen, w_wen, x_load, m_memop, lsu_done, x_redirect;
    logic        en_D, en_X, en_M, en_W, vD, vX, vM, vW;
    logic [1:0]  fwd1, fwd2;
    logic [31:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(.CNT_W(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_flush(if_flush),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use1(d_use1), .d_use2(d_use2),
        .x_rd(x_rd), .m_rd(m_rd), .w_rd(w_rd), .x_wen(x_wen), .m_wen(m_wen), .w_wen(w_wen),
        .x_load(x_load), .m_memop(m_memop), .lsu_done(lsu_done), .x_redirect(x_redirect),
        .en_D(en_D), .en_X(en_X), .en_M(en_M), .en_W(en_W),
        .vD(vD), .vX(vX), .vM(vM), .vW(vW), .fwd1(fwd1), .fwd2(fwd2),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_valids(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, vD, vX, vM, vW}, {28'd0, exp});
    endtask

    task automatic clear_fields();
        d_rs1 = 5'd0; d_rs2 = 5'd0; d_use1 = 1'b0; d_use2 = 1'b0;
        x_rd = 5'd0; m_rd = 5'd0; w_rd = 5'd0;
        x_wen = 1'b0; m_wen = 1'b0; w_wen = 1'b0; x_load = 1'b0;
        m_memop = 1'b0; lsu_done = 1'b0; x_redirect = 1'b0;
    endtask

    task automatic set_load_use();
        x_rd = 5'd5; x_wen = 1'b1; x_load = 1'b1; d_rs1 = 5'd5; d_use1 = 1'b1;
    endtask

    initial begin
        clear_fields();
        if_valid = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_valids("rst_valids", 4'b0000);
        check("rst_stall", stall_cnt, 32'd0);
        check("rst_flush", flush_cnt, 32'd0);
        check("rst_en", {28'd0, en_D, en_X, en_M, en_W}, 32'd0);
        check("rst_ready_flush", {30'd0, if_ready, if_flush}, 32'd0);

        @(posedge clk);
        #1 rst = 1'b0;
        if_valid = 1'b1;
        #1;
        check("start_en", {28'd0, en_D, en_X, en_M, en_W}, 32'hF);
        check("start_ready", {31'd0, if_ready}, 32'd1);

        // Fill: one stage per edge.
        tick(); check_valids("fill1", 4'b1000);
        tick(); check_valids("fill2", 4'b1100);
        tick(); check_valids("fill3", 4'b1110);
        tick(); check_valids("fill4", 4'b1111);
        check("fill_stall", stall_cnt, 32'd0);

        // ALU result forwarded from X; x0 never forwarded.
        x_rd = 5'd3; x_wen = 1'b1; d_rs2 = 5'd3; d_use2 = 1'b1;
        #1;
        check("fwd2_x", {30'd0, fwd2}, 32'd1);
        check("fwd_x_nostall", {31'd0, en_D}, 32'd1);
        check("fwd1_rf", {30'd0, fwd1}, 32'd0);
        x_rd = 5'd0; d_rs2 = 5'd0;
        #1;
        check("fwd2_x0", {30'd0, fwd2}, 32'd0);
        clear_fields();
        // W hit, then M takes priority over W.
        w_rd = 5'd7; w_wen = 1'b1; d_rs1 = 5'd7; d_use1 = 1'b1;
        #1;
        check("fwd1_w", {30'd0, fwd1}, 32'd3);
        m_rd = 5'd7; m_wen = 1'b1;
        #1;
        check("fwd1_m_over_w", {30'd0, fwd1}, 32'd2);
        clear_fields();

        // Load-use: one bubble, then forward from M.
        set_load_use();
        #1;
        check("lu_en_D", {31'd0, en_D}, 32'd0);
        check("lu_ready", {31'd0, if_ready}, 32'd0);
        check("lu_en_X", {31'd0, en_X}, 32'd1);
        check("lu_fwd1", {30'd0, fwd1}, 32'd0);
        tick();
        check_valids("lu_bubble", 4'b1011);
        check("lu_stall", stall_cnt, 32'd1);
        clear_fields();
        m_rd = 5'd5; m_wen = 1'b1; d_rs1 = 5'd5; d_use1 = 1'b1;
        #1;
        check("post_lu_fwd1", {30'd0, fwd1}, 32'd2);
        check("post_lu_en_D", {31'd0, en_D}, 32'd1);
        tick();
        check_valids("post_lu", 4'b1101);
        clear_fields();

        // Redirect with a concurrent load-use: redirect wins.
        set_load_use();
        x_redirect = 1'b1;
        #1;
        check("redir_flush", {31'd0, if_flush}, 32'd1);
        check("redir_ready", {31'd0, if_ready}, 32'd0);
        check("redir_en_D", {31'd0, en_D}, 32'd1);
        tick();
        check_valids("redir_squash", 4'b0010);
        check("redir_flush_cnt", flush_cnt, 32'd1);
        check("redir_stall_cnt", stall_cnt, 32'd1);
        clear_fields();
        #1;
        check("redir_pulse", {31'd0, if_flush}, 32'd0);
        tick(); check_valids("refill1", 4'b1001);
        tick(); check_valids("refill2", 4'b1100);
        tick(); check_valids("refill3", 4'b1110);

        // LSU hold with pending redirect and load-use: nothing moves or counts.
        m_memop = 1'b1; lsu_done = 1'b0; x_redirect = 1'b1;
        set_load_use();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_en", {28'd0, en_D, en_X, en_M, en_W}, 32'h1);
            check("hold_flush", {31'd0, if_flush}, 32'd0);
            tick();
            check_valids("hold_valids", 4'b1110);
            check("hold_flush_cnt", flush_cnt, 32'd1);
            check("hold_stall_cnt", stall_cnt, 32'd1);
        end
        lsu_done = 1'b1;
        #1;
        check("release_flush", {31'd0, if_flush}, 32'd1);
        tick();
        check_valids("release", 4'b0011);
        check("release_flush_cnt", flush_cnt, 32'd2);
        check("release_stall_cnt", stall_cnt, 32'd1);
        clear_fields();

        // Async reset between edges during a load-use.
        tick(); check_valids("pre_rst1", 4'b1001);
        tick(); check_valids("pre_rst2", 4'b1100);
        set_load_use();
        #3 rst = 1'b1;
        #1;
        check_valids("async_rst_valids", 4'b0000);
        check("async_rst_stall", stall_cnt, 32'd0);
        check("async_rst_flush", flush_cnt, 32'd0);
        check("async_rst_en", {28'd0, en_D, en_X, en_M, en_W}, 32'd0);
        #1 rst = 1'b0;
        clear_fields();
        tick();
        check_valids("after_rst", 4'b1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the five-stage NPC pipeline (F→D→X→M→W).
- Owns the valid bits of the D/X/M/W stage registers and drives the load-enable for every stage-register bank: Dstage, Xstage_bus-style X register, M and W.
- Detects load-use RAW hazards and generates forwarding selects.
- Flushes younger stages on a redirect from X (taken branch, jump, jalr, ecall, mret).
- Stalls the pipe while the LSU has an outstanding memory access.

Parameters:
- CNT_W, 32, width of the performance counters (stall and flush).
- FWD_EN, 1, 1 = forwarding enabled; 0 = every RAW hazard stalls until the producer retires from W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  IFU presents a fetched instruction.
- if_ready  out  1  D register accepts it this cycle.
- if_flush  out  1  discard the in-flight fetch; 1-cycle pulse.
- d_rs1, d_rs2  in  5 each  source regs of the instruction in D.
- d_use1, d_use2  in  1 each  instruction in D reads rs1 / rs2.
- x_rd, m_rd, w_rd  in  5 each  destination reg in X / M / W.
- x_wen, m_wen, w_wen  in  1 each  stage writes the register file.
- x_load  in  1  instruction in X is a load.
- m_memop  in  1  instruction in M accesses memory.
- lsu_done  in  1  LSU completes the M access this cycle.
- x_redirect  in  1  X resolves a control transfer (taken branch/jump/ecall/mret).
- en_D, en_X, en_M, en_W  out  1 each  load enable for each stage register.
- vD, vX, vM, vW  out  1 each  stage-register valid bits (registered).
- fwd1, fwd2  out  2 each  operand select for D→X: 00 regfile, 01 X result, 10 M result, 11 W result.
- stall_cnt  out  CNT_W  cycles with a load-use bubble inserted.
- flush_cnt  out  CNT_W  redirects taken.

Behaviour:
- Reset (async, rst=1): vD=vX=vM=vW=0, stall_cnt=flush_cnt=0, en_*=0, if_ready=0, if_flush=0, fwd=00. On deassert the pipe starts empty and accepts from the next edge. Reset mid-operation drops all in-flight instructions; no partial writeback.
- Hazard terms:
  - m_hold = vM & m_memop & ~lsu_done.
  - hit(s,r) = v_s & s_wen & (s_rd == r) & (r != 0).
  - lu = vD & vX & x_load & ((d_use1 & hit(X,d_rs1)) | (d_use2 & hit(X,d_rs2))).
  - With FWD_EN=0, lu extends to any hit in X/M/W.
  - redir = vX & x_redirect & ~m_hold.
- Advance rules, combinational, evaluated every cycle:
  - en_W = 1, always. vW <= vM & ~m_hold.
  - en_M = ~m_hold. When held: vM unchanged, vW <= 0 (bubble into W).
  - en_X = ~m_hold.
    - If redir: vX <= 0 (bubble).
    - Else if lu: vX <= 0 (bubble).
    - Else: vX <= vD.
  - en_D = ~m_hold & ~lu, or redir.
    - If redir: vD <= 0.
    - Else if en_D: vD <= if_valid.
  - if_ready = en_D & ~redir. if_flush = redir.
- Priority: rst > m_hold > redir > lu.
  - A redirect kills the D instruction even when lu is true.
  - While m_hold, no redirect is acted on; it is re-evaluated next cycle because X is held.
- Forwarding (FWD_EN=1), per operand, highest first:
  - X hit, only when not x_load → 01.
  - else M hit → 10.
  - else W hit → 11.
  - else 00.
  - Register x0 is never forwarded.
- Counters: stall_cnt +1 in each cycle with lu & ~m_hold & ~redir. flush_cnt +1 on each redir. Both wrap modulo 2^CNT_W.
- Latency:
  - A load-use costs exactly 1 bubble.
  - A redirect costs 2 squashed slots: D, plus the fetch in flight.
  - The controller adds no cycle on the hazard-free path.
- Simultaneous events:
  - if_valid=0 while advancing → D bubble (vD<=0).
  - lu & m_hold → hold everything; do not count.

Decomposition:
- Shared package `pipe_pkg`:
  - FWD_* encodings (FWD_RF=2'b00, FWD_X=2'b01, FWD_M=2'b10, FWD_W=2'b11).
  - REG_ZERO=5'd0.
- One natural sub-module, `raw_detect`: purely combinational; computes hit/lu/fwd for one source operand; instantiated twice (rs1, rs2).
- Valid bits and counters stay in the top module.

Test Plan:
- Reset then stream: rst 1→0, if_valid=1 for 5 cycles → vD..vW fill one per cycle; vW=1 at cycle 4; stall_cnt=0.
- Load-use: X=lw x5 (x_load=1, x_rd=5, x_wen=1), D=add reads rs1=5 → en_D=0, if_ready=0, vX<=0 for 1 cycle; then fwd1=10; stall_cnt=1.
- ALU forwarding: X=addi x3 (x_load=0), D uses rs2=3 → fwd2=01, no stall. Same with x_rd=0 → fwd2=00.
- Redirect: vX=1, x_redirect=1, vD=1 → if_flush=1 for 1 cycle, vD=0 and vX=0 next cycle, flush_cnt=1. Concurrent lu is ignored; stall_cnt unchanged.
- LSU stall: vM=1, m_memop=1, lsu_done=0 for 3 cycles → en_D/en_X/en_M=0 and vW=0 for those 3 cycles; x_redirect held high produces no flush until lsu_done=1.
- Async reset mid-stall: rst pulsed between edges during a lu → all valids and counters read 0 immediately, before the next clk edge.
